// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: opcode and shift-control encodings,
// instruction field positions, and the registered issue bundle.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;

  localparam logic [2:0] SR_NONE = 3'd0;
  localparam logic [2:0] SR_RSH  = 3'd1;
  localparam logic [2:0] SR_LSH  = 3'd2;
  localparam logic [2:0] SR_ROR  = 3'd3;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 28;
  localparam int SRC_MSB = 27;
  localparam int SRC_LSB = 25;
  localparam int SRB_MSB = 24;
  localparam int SRB_LSB = 20;
  localparam int RD_MSB  = 19;
  localparam int RD_LSB  = 15;
  localparam int RS1_MSB = 14;
  localparam int RS1_LSB = 10;
  localparam int RS2_MSB = 9;
  localparam int RS2_LSB = 5;

  // Source indices ride along with the operands so a stalled bundle can be refreshed.
  typedef struct packed {
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  opcode;
    logic [2:0]  sr_cont;
    logic [4:0]  sr_bit;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } issue_bundle_t;

  function automatic logic is_legal(input logic [3:0] op, input logic [2:0] sc);
    return (op <= OP_XOR) && (sc <= SR_ROR);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file with two combinational read ports and one write port;
// r0 reads as zero and ignores writes.
module alu_regfile #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr1,
  output logic [31:0]   data1,
  input  logic [AW-1:0] addr2,
  output logic [31:0]   data2,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata
);

  logic [31:0] mem [NREGS];

  // NOTE: this array is flop-based so it can be cleared by reset; a macro RAM could not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign data1 = (addr1 == '0) ? 32'd0 : mem[addr1];
  assign data2 = (addr2 == '0) ? 32'd0 : mem[addr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/operand-issue stage: decodes instruction words, reads operands with
// writeback forwarding, and holds a refreshable ALU-ready bundle.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_in1,
  output logic [31:0]      out_in2,
  output logic [3:0]       out_opcode,
  output logic [2:0]       out_sr_cont,
  output logic [4:0]       out_sr_bit,
  output logic [4:0]       out_rd,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state_q, state_d;
  issue_bundle_t bundle_q, bundle_d, captured;

  logic [3:0]  dec_opcode;
  logic [2:0]  dec_sr_cont;
  logic [4:0]  dec_rs1, dec_rs2;
  logic [31:0] rf_data1, rf_data2;
  logic        accept, legal;
  logic        unused_reserved;

  assign dec_opcode      = in_instr[OPC_MSB:OPC_LSB];
  assign dec_sr_cont     = in_instr[SRC_MSB:SRC_LSB];
  assign dec_rs1         = in_instr[RS1_MSB:RS1_LSB];
  assign dec_rs2         = in_instr[RS2_MSB:RS2_LSB];
  assign unused_reserved = ^in_instr[4:0];

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign legal     = is_legal(dec_opcode, dec_sr_cont);

  alu_regfile #(.NREGS(NREGS)) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .addr1 (dec_rs1),
    .data1 (rf_data1),
    .addr2 (dec_rs2),
    .data2 (rf_data2),
    .we    (wb_en),
    .waddr (wb_addr),
    .wdata (wb_data)
  );

  // The array only updates at the edge, so a same-cycle writeback is forwarded here.
  always_comb begin
    captured.in1     = (wb_en && wb_addr == dec_rs1 && dec_rs1 != '0) ? wb_data : rf_data1;
    captured.in2     = (wb_en && wb_addr == dec_rs2 && dec_rs2 != '0) ? wb_data : rf_data2;
    captured.opcode  = dec_opcode;
    captured.sr_cont = dec_sr_cont;
    captured.sr_bit  = in_instr[SRB_MSB:SRB_LSB];
    captured.rd      = in_instr[RD_MSB:RD_LSB];
    captured.rs1     = dec_rs1;
    captured.rs2     = dec_rs2;
  end

  // NOTE: defaults first so every path assigns every bit and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    if (accept && legal) begin
      state_d  = FULL;
      bundle_d = captured;
    end else if (state_q == FULL) begin
      if (out_ready) begin
        state_d = EMPTY;
      end else begin
        if (wb_en && wb_addr == bundle_q.rs1 && bundle_q.rs1 != '0) bundle_d.in1 = wb_data;
        if (wb_en && wb_addr == bundle_q.rs2 && bundle_q.rs2 != '0) bundle_d.in2 = wb_data;
      end
    end
  end

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      bundle_q    <= '0;
      illegal     <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      illegal  <= accept && !legal;
      if (accept && !legal && (illegal_cnt != {CNT_W{1'b1}}))
        illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_in1     = bundle_q.in1;
  assign out_in2     = bundle_q.in2;
  assign out_opcode  = bundle_q.opcode;
  assign out_sr_cont = bundle_q.sr_cont;
  assign out_sr_bit  = bundle_q.sr_bit;
  assign out_rd      = bundle_q.rd;

endmodule
